// File: rtl/minisrc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : minisrc_pkg
// Description : Shared definitions for the Mini SRC hardwired controller:
//               opcode constants, controller state encoding and the
//               instruction-class encoding produced by the opcode decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package minisrc_pkg;

    localparam int c_OPCODE_W = 5;
    localparam int c_ALU_OP_W = 5;

    // Opcodes held in IR[31:27]
    localparam logic [4:0] c_OP_LD   = 5'b00000;
    localparam logic [4:0] c_OP_LDI  = 5'b00001;
    localparam logic [4:0] c_OP_ST   = 5'b00010;
    localparam logic [4:0] c_OP_ADD  = 5'b00011;
    localparam logic [4:0] c_OP_SUB  = 5'b00100;
    localparam logic [4:0] c_OP_AND  = 5'b00101;
    localparam logic [4:0] c_OP_OR   = 5'b00110;
    localparam logic [4:0] c_OP_ROR  = 5'b00111;
    localparam logic [4:0] c_OP_ROL  = 5'b01000;
    localparam logic [4:0] c_OP_SHR  = 5'b01001;
    localparam logic [4:0] c_OP_SHRA = 5'b01010;
    localparam logic [4:0] c_OP_SHL  = 5'b01011;
    localparam logic [4:0] c_OP_ADDI = 5'b01100;
    localparam logic [4:0] c_OP_ANDI = 5'b01101;
    localparam logic [4:0] c_OP_ORI  = 5'b01110;
    localparam logic [4:0] c_OP_MUL  = 5'b01111;
    localparam logic [4:0] c_OP_DIV  = 5'b10000;
    localparam logic [4:0] c_OP_NEG  = 5'b10001;
    localparam logic [4:0] c_OP_NOT  = 5'b10010;
    localparam logic [4:0] c_OP_BR   = 5'b10011;
    localparam logic [4:0] c_OP_JR   = 5'b10100;
    localparam logic [4:0] c_OP_JAL  = 5'b10101;
    localparam logic [4:0] c_OP_IN   = 5'b10110;
    localparam logic [4:0] c_OP_OUT  = 5'b10111;
    localparam logic [4:0] c_OP_MFHI = 5'b11000;
    localparam logic [4:0] c_OP_MFLO = 5'b11001;
    localparam logic [4:0] c_OP_NOP  = 5'b11010;
    localparam logic [4:0] c_OP_HALT = 5'b11011;

    // T-states are consecutive so the step index is (state - ST_T0)
    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_T7   = 4'd8,
        ST_HALT = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        CLS_ALU_R  = 4'd0,
        CLS_ALU_I  = 4'd1,
        CLS_UNARY  = 4'd2,
        CLS_MULDIV = 4'd3,
        CLS_LD     = 4'd4,
        CLS_LDI    = 4'd5,
        CLS_ST     = 4'd6,
        CLS_BR     = 4'd7,
        CLS_JR     = 4'd8,
        CLS_JAL    = 4'd9,
        CLS_IN     = 4'd10,
        CLS_OUT    = 4'd11,
        CLS_MFHI   = 4'd12,
        CLS_MFLO   = 4'd13,
        CLS_NOP    = 4'd14,
        CLS_HALT   = 4'd15
    } class_t;

endpackage : minisrc_pkg
`default_nettype wire

// File: rtl/control_decode.sv
`default_nettype none
// ============================================================================
// Module      : control_decode
// Description : Combinational opcode decoder. Maps an opcode to its
//               instruction class, the ALU operation used in the step that
//               loads Z, and the index of the final T-step of the class.
// Ports       : i_opcode    - opcode field IR[31:27]
//               o_class     - instruction class
//               o_alu_op    - ALU operation for the Z-load step
//               o_last_step - last T-step index (3..7)
// Revision    : 1.0 - initial release
// ============================================================================
module control_decode
    import minisrc_pkg::*;
#(
    parameter int OPCODE_W = 5,
    parameter int ALU_OP_W = 5
) (
    input  logic [OPCODE_W-1:0] i_opcode,
    output class_t              o_class,
    output logic [ALU_OP_W-1:0] o_alu_op,
    output logic [2:0]          o_last_step
);

    always_comb begin
        // Undefined opcodes fall through as a single empty T3 step
        o_class     = CLS_NOP;
        o_alu_op    = '0;
        o_last_step = 3'd3;
        case (i_opcode)
            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_ROR,
            c_OP_ROL, c_OP_SHR, c_OP_SHRA, c_OP_SHL: begin
                o_class     = CLS_ALU_R;
                o_alu_op    = ALU_OP_W'(i_opcode);
                o_last_step = 3'd5;
            end
            // Immediate forms reuse the register-form ALU codes
            c_OP_ADDI: begin
                o_class     = CLS_ALU_I;
                o_alu_op    = ALU_OP_W'(c_OP_ADD);
                o_last_step = 3'd5;
            end
            c_OP_ANDI: begin
                o_class     = CLS_ALU_I;
                o_alu_op    = ALU_OP_W'(c_OP_AND);
                o_last_step = 3'd5;
            end
            c_OP_ORI: begin
                o_class     = CLS_ALU_I;
                o_alu_op    = ALU_OP_W'(c_OP_OR);
                o_last_step = 3'd5;
            end
            c_OP_NEG, c_OP_NOT: begin
                o_class     = CLS_UNARY;
                o_alu_op    = ALU_OP_W'(i_opcode);
                o_last_step = 3'd4;
            end
            c_OP_MUL, c_OP_DIV: begin
                o_class     = CLS_MULDIV;
                o_alu_op    = ALU_OP_W'(i_opcode);
                o_last_step = 3'd6;
            end
            // Memory and branch forms compute an address with ADD
            c_OP_LD: begin
                o_class     = CLS_LD;
                o_alu_op    = ALU_OP_W'(c_OP_ADD);
                o_last_step = 3'd7;
            end
            c_OP_LDI: begin
                o_class     = CLS_LDI;
                o_alu_op    = ALU_OP_W'(c_OP_ADD);
                o_last_step = 3'd5;
            end
            c_OP_ST: begin
                o_class     = CLS_ST;
                o_alu_op    = ALU_OP_W'(c_OP_ADD);
                o_last_step = 3'd7;
            end
            c_OP_BR: begin
                o_class     = CLS_BR;
                o_alu_op    = ALU_OP_W'(c_OP_ADD);
                o_last_step = 3'd6;
            end
            c_OP_JR:   o_class = CLS_JR;
            c_OP_JAL: begin
                o_class     = CLS_JAL;
                o_last_step = 3'd4;
            end
            c_OP_IN:   o_class = CLS_IN;
            c_OP_OUT:  o_class = CLS_OUT;
            c_OP_MFHI: o_class = CLS_MFHI;
            c_OP_MFLO: o_class = CLS_MFLO;
            c_OP_HALT: o_class = CLS_HALT;
            default:   o_class = CLS_NOP;
        endcase
    end

endmodule : control_decode
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Hardwired Moore controller for the Mini SRC datapath. Runs
//               the fetch sequence T0-T2, then the per-class T3..T7 steps,
//               returning to T0 (or HALT when Stop is raised) at the
//               instruction boundary.
// Ports       : clk, clr        - clock, synchronous active-high reset
//               IR_Data         - instruction register contents
//               CON_out         - branch condition, used in br T6
//               Stop            - halt at the next instruction boundary
//               Run             - high while executing
//               *_in / IncPC    - register load strobes
//               *_out / C_out   - bus drive strobes
//               Read, Write     - memory strobes
//               Gra..BAout      - register select/encode controls
//               alu_instruction_bits - ALU op in Z-computing steps, else 0
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit
    import minisrc_pkg::*;
#(
    parameter int OPCODE_W = 5,
    parameter int ALU_OP_W = 5
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [31:0]         IR_Data,
    input  logic                CON_out,
    input  logic                Stop,
    output logic                Run,
    output logic                PC_in, IR_in, Y_in, Z_in, HI_in, LO_in,
    output logic                MAR_in, MDR_in, OutPort_in, CON_in, IncPC,
    output logic                PC_out, Zhigh_out, Zlow_out, HI_out, LO_out,
    output logic                MDR_out, InPort_out, C_out,
    output logic                Read, Write,
    output logic                Gra, Grb, Grc, Rin, Rout, BAout,
    output logic [ALU_OP_W-1:0] alu_instruction_bits
);

    state_t                r_state;
    state_t                w_next;
    logic [OPCODE_W-1:0]   r_opcode;
    logic [OPCODE_W-1:0]   w_opcode;
    class_t                w_class;
    logic [ALU_OP_W-1:0]   w_alu_op;
    logic [2:0]            w_last_step;
    logic [2:0]            w_step;
    logic                  w_ir_unused;

    assign w_ir_unused = ^IR_Data[31-OPCODE_W:0];

    // IR is only valid from T3; use it directly in T3 and the copy latched
    // at the end of T3 for the remaining steps.
    assign w_opcode = (r_state == ST_T3) ? IR_Data[31 -: OPCODE_W] : r_opcode;
    assign w_step   = 3'(4'(r_state) - 4'(ST_T0));

    control_decode #(
        .OPCODE_W (OPCODE_W),
        .ALU_OP_W (ALU_OP_W)
    ) u_decode (
        .i_opcode    (w_opcode),
        .o_class     (w_class),
        .o_alu_op    (w_alu_op),
        .o_last_step (w_last_step)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state  <= ST_RST;
            r_opcode <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_T3) r_opcode <= IR_Data[31 -: OPCODE_W];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RST:  w_next = ST_T0;
            ST_T0:   w_next = ST_T1;
            ST_T1:   w_next = ST_T2;
            ST_T2:   w_next = ST_T3;
            ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
                if (w_step == w_last_step)
                    w_next = (w_class == CLS_HALT || Stop) ? ST_HALT : ST_T0;
                else
                    w_next = state_t'(4'(r_state) + 4'd1);
            end
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_RST;
        endcase
    end

    always_comb begin
        Run = 1'b0;
        PC_in = 1'b0; IR_in = 1'b0; Y_in = 1'b0; Z_in = 1'b0; HI_in = 1'b0;
        LO_in = 1'b0; MAR_in = 1'b0; MDR_in = 1'b0; OutPort_in = 1'b0;
        CON_in = 1'b0; IncPC = 1'b0;
        PC_out = 1'b0; Zhigh_out = 1'b0; Zlow_out = 1'b0; HI_out = 1'b0;
        LO_out = 1'b0; MDR_out = 1'b0; InPort_out = 1'b0; C_out = 1'b0;
        Read = 1'b0; Write = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        alu_instruction_bits = '0;

        if (r_state != ST_RST && r_state != ST_HALT) Run = 1'b1;

        case (r_state)
            ST_T0: begin PC_out = 1'b1; MAR_in = 1'b1; IncPC = 1'b1; Z_in = 1'b1; end
            ST_T1: begin Zlow_out = 1'b1; PC_in = 1'b1; Read = 1'b1; MDR_in = 1'b1; end
            ST_T2: begin MDR_out = 1'b1; IR_in = 1'b1; end
            ST_T3: begin
                case (w_class)
                    CLS_ALU_R, CLS_ALU_I: begin Grb = 1'b1; Rout = 1'b1; Y_in = 1'b1; end
                    CLS_UNARY: begin
                        Grb = 1'b1; Rout = 1'b1; Z_in = 1'b1;
                        alu_instruction_bits = w_alu_op;
                    end
                    CLS_MULDIV: begin Gra = 1'b1; Rout = 1'b1; Y_in = 1'b1; end
                    CLS_LD, CLS_LDI, CLS_ST: begin Grb = 1'b1; BAout = 1'b1; Y_in = 1'b1; end
                    CLS_BR:   begin Gra = 1'b1; Rout = 1'b1; CON_in = 1'b1; end
                    CLS_JR:   begin Gra = 1'b1; Rout = 1'b1; PC_in = 1'b1; end
                    CLS_JAL:  begin PC_out = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                    CLS_IN:   begin InPort_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CLS_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPort_in = 1'b1; end
                    CLS_MFHI: begin HI_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CLS_MFLO: begin LO_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default:  ;
                endcase
            end
            ST_T4: begin
                case (w_class)
                    CLS_ALU_R: begin
                        Grc = 1'b1; Rout = 1'b1; Z_in = 1'b1;
                        alu_instruction_bits = w_alu_op;
                    end
                    CLS_ALU_I, CLS_LD, CLS_LDI, CLS_ST: begin
                        C_out = 1'b1; Z_in = 1'b1;
                        alu_instruction_bits = w_alu_op;
                    end
                    CLS_UNARY: begin Zlow_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CLS_MULDIV: begin
                        Grb = 1'b1; Rout = 1'b1; Z_in = 1'b1;
                        alu_instruction_bits = w_alu_op;
                    end
                    CLS_BR:  begin PC_out = 1'b1; Y_in = 1'b1; end
                    CLS_JAL: begin Gra = 1'b1; Rout = 1'b1; PC_in = 1'b1; end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (w_class)
                    CLS_ALU_R, CLS_ALU_I, CLS_LDI: begin Zlow_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CLS_MULDIV: begin Zlow_out = 1'b1; LO_in = 1'b1; end
                    CLS_LD, CLS_ST: begin Zlow_out = 1'b1; MAR_in = 1'b1; end
                    CLS_BR: begin
                        C_out = 1'b1; Z_in = 1'b1;
                        alu_instruction_bits = w_alu_op;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (w_class)
                    CLS_MULDIV: begin Zhigh_out = 1'b1; HI_in = 1'b1; end
                    CLS_LD:     begin Read = 1'b1; MDR_in = 1'b1; end
                    CLS_ST:     begin Gra = 1'b1; Rout = 1'b1; MDR_in = 1'b1; end
                    // Branch target is committed only when the condition holds
                    CLS_BR:     begin Zlow_out = CON_out; PC_in = CON_out; end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (w_class)
                    CLS_LD:  begin MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CLS_ST:  Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule : control_unit
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit
// Description : Scoreboard bench for control_unit. The stimulus process
//               pushes the expected strobe word for each cycle; a monitor on
//               the falling edge pops and compares against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;

    localparam logic [27:0] M_PC_IN   = 28'd1 << 0;
    localparam logic [27:0] M_IR_IN   = 28'd1 << 1;
    localparam logic [27:0] M_Y_IN    = 28'd1 << 2;
    localparam logic [27:0] M_Z_IN    = 28'd1 << 3;
    localparam logic [27:0] M_HI_IN   = 28'd1 << 4;
    localparam logic [27:0] M_LO_IN   = 28'd1 << 5;
    localparam logic [27:0] M_MAR_IN  = 28'd1 << 6;
    localparam logic [27:0] M_MDR_IN  = 28'd1 << 7;
    localparam logic [27:0] M_OUTP_IN = 28'd1 << 8;
    localparam logic [27:0] M_CON_IN  = 28'd1 << 9;
    localparam logic [27:0] M_INCPC   = 28'd1 << 10;
    localparam logic [27:0] M_PC_OUT  = 28'd1 << 11;
    localparam logic [27:0] M_ZHI_OUT = 28'd1 << 12;
    localparam logic [27:0] M_ZLO_OUT = 28'd1 << 13;
    localparam logic [27:0] M_HI_OUT  = 28'd1 << 14;
    localparam logic [27:0] M_LO_OUT  = 28'd1 << 15;
    localparam logic [27:0] M_MDR_OUT = 28'd1 << 16;
    localparam logic [27:0] M_INP_OUT = 28'd1 << 17;
    localparam logic [27:0] M_C_OUT   = 28'd1 << 18;
    localparam logic [27:0] M_READ    = 28'd1 << 19;
    localparam logic [27:0] M_WRITE   = 28'd1 << 20;
    localparam logic [27:0] M_GRA     = 28'd1 << 21;
    localparam logic [27:0] M_GRB     = 28'd1 << 22;
    localparam logic [27:0] M_GRC     = 28'd1 << 23;
    localparam logic [27:0] M_RIN     = 28'd1 << 24;
    localparam logic [27:0] M_ROUT    = 28'd1 << 25;
    localparam logic [27:0] M_BAOUT   = 28'd1 << 26;
    localparam logic [27:0] M_RUN     = 28'd1 << 27;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] IR_Data;
    logic        CON_out;
    logic        Stop;
    logic        Run;
    logic        PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in;
    logic        OutPort_in, CON_in, IncPC;
    logic        PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out;
    logic        Read, Write;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic [4:0]  alu_instruction_bits;
    logic [27:0] obs;

    int n_checks = 0;
    int n_errors = 0;

    logic [27:0] sb_s[$];
    logic [4:0]  sb_a[$];
    string       sb_n[$];

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .clr(clr), .IR_Data(IR_Data), .CON_out(CON_out), .Stop(Stop),
        .Run(Run),
        .PC_in(PC_in), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in), .HI_in(HI_in),
        .LO_in(LO_in), .MAR_in(MAR_in), .MDR_in(MDR_in), .OutPort_in(OutPort_in),
        .CON_in(CON_in), .IncPC(IncPC),
        .PC_out(PC_out), .Zhigh_out(Zhigh_out), .Zlow_out(Zlow_out), .HI_out(HI_out),
        .LO_out(LO_out), .MDR_out(MDR_out), .InPort_out(InPort_out), .C_out(C_out),
        .Read(Read), .Write(Write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .alu_instruction_bits(alu_instruction_bits)
    );

    assign obs = {Run, BAout, Rout, Rin, Grc, Grb, Gra, Write, Read, C_out,
                  InPort_out, MDR_out, LO_out, HI_out, Zlow_out, Zhigh_out, PC_out,
                  IncPC, CON_in, OutPort_in, MDR_in, MAR_in, LO_in, HI_in, Z_in,
                  Y_in, IR_in, PC_in};

    // Monitor: one expected word per cycle, compared mid-cycle
    always @(negedge clk) begin
        logic [27:0] es;
        logic [4:0]  ea;
        string       en;
        if (sb_s.size() > 0) begin
            es = sb_s.pop_front();
            ea = sb_a.pop_front();
            en = sb_n.pop_front();
            n_checks++;
            if (obs !== es || alu_instruction_bits !== ea) begin
                n_errors++;
                $display("FAIL %s: got strobes=%07h alu=%05b, required strobes=%07h alu=%05b",
                         en, obs, alu_instruction_bits, es, ea);
            end
        end
    end

    // Push the expectation for the current cycle, then advance one cycle
    task automatic chk(input logic [27:0] s, input logic [4:0] a, input string nm);
        sb_s.push_back(s);
        sb_a.push_back(a);
        sb_n.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag);
        chk(M_RUN | M_PC_OUT | M_MAR_IN | M_INCPC | M_Z_IN, 5'b0, {tag, "_T0"});
        chk(M_RUN | M_ZLO_OUT | M_PC_IN | M_READ | M_MDR_IN, 5'b0, {tag, "_T1"});
        chk(M_RUN | M_MDR_OUT | M_IR_IN, 5'b0, {tag, "_T2"});
    endtask

    task automatic br_seq(input logic cond, input string tag);
        IR_Data = 32'h9800_0000;
        CON_out = cond;
        fetch(tag);
        chk(M_RUN | M_GRA | M_ROUT | M_CON_IN, 5'b0, {tag, "_T3"});
        chk(M_RUN | M_PC_OUT | M_Y_IN, 5'b0, {tag, "_T4"});
        chk(M_RUN | M_C_OUT | M_Z_IN, 5'b00011, {tag, "_T5"});
        chk(cond ? (M_RUN | M_ZLO_OUT | M_PC_IN) : M_RUN, 5'b0, {tag, "_T6"});
    endtask

    initial begin
        clr = 1'b1; Stop = 1'b0; CON_out = 1'b0; IR_Data = 32'h6918_0025;
        repeat (2) @(posedge clk);
        #1;
        chk(28'd0, 5'b0, "rst_hold");
        clr = 1'b0;
        chk(28'd0, 5'b0, "rst_exit");

        // andi
        fetch("andi");
        chk(M_RUN | M_GRB | M_ROUT | M_Y_IN, 5'b0, "andi_T3");
        chk(M_RUN | M_C_OUT | M_Z_IN, 5'b00101, "andi_T4");
        chk(M_RUN | M_ZLO_OUT | M_GRA | M_RIN, 5'b0, "andi_T5");

        // br not taken / taken (each ends in T0, checked by the next fetch)
        br_seq(1'b0, "br_nt");
        br_seq(1'b1, "br_tk");

        // st
        IR_Data = 32'h1000_0000;
        fetch("st");
        chk(M_RUN | M_GRB | M_BAOUT | M_Y_IN, 5'b0, "st_T3");
        chk(M_RUN | M_C_OUT | M_Z_IN, 5'b00011, "st_T4");
        chk(M_RUN | M_ZLO_OUT | M_MAR_IN, 5'b0, "st_T5");
        chk(M_RUN | M_GRA | M_ROUT | M_MDR_IN, 5'b0, "st_T6");
        chk(M_RUN | M_WRITE, 5'b0, "st_T7");

        // mul
        IR_Data = 32'h7800_0000;
        fetch("mul");
        chk(M_RUN | M_GRA | M_ROUT | M_Y_IN, 5'b0, "mul_T3");
        chk(M_RUN | M_GRB | M_ROUT | M_Z_IN, 5'b01111, "mul_T4");
        chk(M_RUN | M_ZLO_OUT | M_LO_IN, 5'b0, "mul_T5");
        chk(M_RUN | M_ZHI_OUT | M_HI_IN, 5'b0, "mul_T6");

        // ori uses the OR code, not the opcode
        IR_Data = 32'h7000_0000;
        fetch("ori");
        chk(M_RUN | M_GRB | M_ROUT | M_Y_IN, 5'b0, "ori_T3");
        chk(M_RUN | M_C_OUT | M_Z_IN, 5'b00110, "ori_T4");
        chk(M_RUN | M_ZLO_OUT | M_GRA | M_RIN, 5'b0, "ori_T5");

        // jal
        IR_Data = 32'hA800_0000;
        fetch("jal");
        chk(M_RUN | M_PC_OUT | M_GRB | M_RIN, 5'b0, "jal_T3");
        chk(M_RUN | M_GRA | M_ROUT | M_PC_IN, 5'b0, "jal_T4");

        // undefined opcode: one empty T3
        IR_Data = 32'hF800_0000;
        fetch("undef");
        chk(M_RUN, 5'b0, "undef_T3");

        // ld interrupted by clr during T5
        IR_Data = 32'h0000_0000;
        fetch("ld");
        chk(M_RUN | M_GRB | M_BAOUT | M_Y_IN, 5'b0, "ld_T3");
        chk(M_RUN | M_C_OUT | M_Z_IN, 5'b00011, "ld_T4");
        clr = 1'b1;
        chk(M_RUN | M_ZLO_OUT | M_MAR_IN, 5'b0, "ld_T5");
        clr = 1'b0;
        chk(28'd0, 5'b0, "ld_clr_rst");

        // add with Stop at the boundary goes to HALT
        IR_Data = 32'h1800_0000;
        fetch("add");
        chk(M_RUN | M_GRB | M_ROUT | M_Y_IN, 5'b0, "add_T3");
        chk(M_RUN | M_GRC | M_ROUT | M_Z_IN, 5'b00011, "add_T4");
        Stop = 1'b1;
        chk(M_RUN | M_ZLO_OUT | M_GRA | M_RIN, 5'b0, "add_T5");
        Stop = 1'b0;
        for (int i = 0; i < 3; i++) chk(28'd0, 5'b0, "stop_halt");
        clr = 1'b1;
        chk(28'd0, 5'b0, "stop_halt_clr");
        clr = 1'b0;
        chk(28'd0, 5'b0, "stop_rst");

        // halt instruction
        IR_Data = 32'hD800_0000;
        fetch("halt");
        chk(M_RUN, 5'b0, "halt_T3");
        for (int i = 0; i < 20; i++) chk(28'd0, 5'b0, "halt_hold");
        clr = 1'b1;
        chk(28'd0, 5'b0, "halt_clr");
        clr = 1'b0;
        IR_Data = 32'hD000_0000;
        chk(28'd0, 5'b0, "halt_rst");
        fetch("nop");
        chk(M_RUN, 5'b0, "nop_T3");
        chk(M_RUN | M_PC_OUT | M_MAR_IN | M_INCPC | M_Z_IN, 5'b0, "nop_next_T0");

        @(negedge clk);
        #1;
        n_checks++;
        if (sb_s.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_s.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule : tb_control_unit
`default_nettype wire
